// File: rtl/dense_mac_if.sv
// dense_mac_if: scheduler/memory bus of the dense MAC engine.
// Signals: start_i/busy_o/done_o layer handshake; in_addr_o/in_data_i input buffer;
// w_addr_o/w_data_i weight ROM; b_addr_o/b_data_i bias ROM; out_addr_o/out_data_o/out_we_o result buffer.
// slave = engine side, master = scheduler and memories side.
interface dense_mac_if #(
   parameter int WIDTH   = 16,
   parameter int LANES   = 5,
   parameter int IN_LEN  = 200,
   parameter int OUT_LEN = 10
);
   localparam int GROUPS = IN_LEN / LANES;
   localparam int GW = GROUPS > 1 ? $clog2(GROUPS) : 1;
   localparam int WW = OUT_LEN * GROUPS > 1 ? $clog2(OUT_LEN * GROUPS) : 1;
   localparam int NW = OUT_LEN > 1 ? $clog2(OUT_LEN) : 1;
   logic                   start_i;
   logic                   busy_o;
   logic                   done_o;
   logic [GW-1:0]          in_addr_o;
   logic [WIDTH*LANES-1:0] in_data_i;
   logic [WW-1:0]          w_addr_o;
   logic [WIDTH*LANES-1:0] w_data_i;
   logic [NW-1:0]          b_addr_o;
   logic [WIDTH-1:0]       b_data_i;
   logic [NW-1:0]          out_addr_o;
   logic [WIDTH-1:0]       out_data_o;
   logic                   out_we_o;
   modport slave (
      input  start_i, in_data_i, w_data_i, b_data_i,
      output busy_o, done_o, in_addr_o, w_addr_o, b_addr_o, out_addr_o, out_data_o, out_we_o
   );
   modport master (
      output start_i, in_data_i, w_data_i, b_data_i,
      input  busy_o, done_o, in_addr_o, w_addr_o, b_addr_o, out_addr_o, out_data_o, out_we_o
   );
endinterface

// File: rtl/dense_mac_engine.sv
// dense_mac_engine: fully-connected layer engine, LANES MACs per cycle, bias add, saturated Q-format output.
// Ports: clk, rst (async, active-high), bus (dense_mac_if.slave: handshake, input/weight/bias reads, result writes).
// Optional: define DENSE_MAC_RELU_EN to clamp negative results to 0 after saturation.
module dense_mac_engine #(
   parameter int WIDTH   = 16,
   parameter int FRAC    = 8,
   parameter int LANES   = 5,
   parameter int IN_LEN  = 200,
   parameter int OUT_LEN = 10
) (
   input logic        clk,
   input logic        rst,
   dense_mac_if.slave bus
);
   localparam int GROUPS = IN_LEN / LANES;
   localparam int ACC_W  = 2 * WIDTH + $clog2(IN_LEN);
   localparam int GW = GROUPS > 1 ? $clog2(GROUPS) : 1;
   localparam int WW = OUT_LEN * GROUPS > 1 ? $clog2(OUT_LEN * GROUPS) : 1;
   localparam int NW = OUT_LEN > 1 ? $clog2(OUT_LEN) : 1;

   if (IN_LEN % LANES != 0) begin : g_len_chk
      $error("IN_LEN must be a multiple of LANES");
   end

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WRITE} state_t;

   state_t                   state;
   logic [GW-1:0]            g;
   logic [NW-1:0]            n;
   logic signed [ACC_W-1:0]  acc, psum, acc_nxt;
   logic signed [2*WIDTH-1:0] prod;
   logic signed [ACC_W:0]    res;
   logic [WIDTH-1:0]         sat, result;

   assign bus.in_addr_o = g;
   assign bus.b_addr_o  = n;

   always_comb begin
      psum = '0;
      prod = '0;
      for (int i = 0; i < LANES; i++) begin
         prod = $signed(bus.in_data_i[i*WIDTH +: WIDTH]) * $signed(bus.w_data_i[i*WIDTH +: WIDTH]);
         psum = psum + ACC_W'(prod);
      end
      acc_nxt = acc + psum;
      res = (ACC_W+1)'(acc_nxt >>> FRAC) + (ACC_W+1)'($signed(bus.b_data_i));
      // in range when every bit above the output sign bit matches it
      sat = (&res[ACC_W:WIDTH-1] || ~|res[ACC_W:WIDTH-1]) ? res[WIDTH-1:0] :
            res[ACC_W] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`ifdef DENSE_MAC_RELU_EN
      result = sat[WIDTH-1] ? '0 : sat;
`else
      result = sat;
`endif
   end

   // The result is registered on the DRAIN->WRITE edge from the final accumulation,
   // so out_we_o is high throughout the WRITE cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         g              <= '0;
         n              <= '0;
         acc            <= '0;
         bus.busy_o     <= 1'b0;
         bus.done_o     <= 1'b0;
         bus.w_addr_o   <= '0;
         bus.out_addr_o <= '0;
         bus.out_data_o <= '0;
         bus.out_we_o   <= 1'b0;
      end else begin
         bus.done_o   <= 1'b0;
         bus.out_we_o <= 1'b0;
         case (state)
            IDLE: if (bus.start_i) begin
               state        <= FETCH;
               g            <= '0;
               n            <= '0;
               acc          <= '0;
               bus.busy_o   <= 1'b1;
               bus.w_addr_o <= '0;
            end
            FETCH: begin
               // data for group g-1 arrives while group g is addressed
               if (g != '0) acc <= acc_nxt;
               if (g == GW'(GROUPS - 1)) state <= DRAIN;
               else begin
                  g            <= g + GW'(1);
                  bus.w_addr_o <= bus.w_addr_o + WW'(1);
               end
            end
            DRAIN: begin
               acc            <= acc_nxt;
               bus.out_addr_o <= n;
               bus.out_data_o <= result;
               bus.out_we_o   <= 1'b1;
               state          <= WRITE;
            end
            WRITE: begin
               acc <= '0;
               if (n == NW'(OUT_LEN - 1)) begin
                  state      <= IDLE;
                  bus.busy_o <= 1'b0;
                  bus.done_o <= 1'b1;
               end else begin
                  state        <= FETCH;
                  n            <= n + NW'(1);
                  g            <= '0;
                  bus.w_addr_o <= bus.w_addr_o + WW'(1);
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dense_mac_engine.sv
// tb_dense_mac_engine: randomized and directed checks of dense_mac_engine against a flat dot-product model.
module tb_dense_mac_engine;
   localparam int WIDTH = 16, FRAC = 8, LANES = 5, IN_LEN = 10, OUT_LEN = 2;
   localparam int GROUPS = IN_LEN / LANES;
   localparam int NEURON_CYC = GROUPS + 2;
   localparam int LAYER_CYC = OUT_LEN * NEURON_CYC + 1;

   logic clk = 0, rst = 0;
   int cyc = 0, n_chk = 0, n_fail = 0;
   int in_v[IN_LEN];
   int w_v[OUT_LEN][IN_LEN];
   int b_v[OUT_LEN];
   longint exp_v[OUT_LEN];
   int wr_e[$], wr_a[$], wr_d[$], dn_e[$];

   dense_mac_if #(.WIDTH(WIDTH), .LANES(LANES), .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN)) bus();
   dense_mac_engine #(.WIDTH(WIDTH), .FRAC(FRAC), .LANES(LANES), .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN))
      dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [WIDTH*LANES-1:0] pack_in(input int g);
      logic [WIDTH*LANES-1:0] r = '0;
      if (g < GROUPS) for (int l = 0; l < LANES; l++) r[l*WIDTH +: WIDTH] = WIDTH'(in_v[g*LANES+l]);
      return r;
   endfunction

   function automatic logic [WIDTH*LANES-1:0] pack_w(input int a);
      logic [WIDTH*LANES-1:0] r = '0;
      if (a < OUT_LEN * GROUPS)
         for (int l = 0; l < LANES; l++) r[l*WIDTH +: WIDTH] = WIDTH'(w_v[a/GROUPS][(a%GROUPS)*LANES+l]);
      return r;
   endfunction

   // synchronous-read memories: data one cycle after address
   always @(posedge clk) begin
      bus.in_data_i <= pack_in(int'(bus.in_addr_o));
      bus.w_data_i  <= pack_w(int'(bus.w_addr_o));
      bus.b_data_i  <= (int'(bus.b_addr_o) < OUT_LEN) ? WIDTH'(b_v[bus.b_addr_o]) : '0;
   end

   // record writes/done with the clock edge at which they are sampled
   always @(negedge clk) begin
      if (bus.out_we_o) begin
         wr_e.push_back(cyc + 1);
         wr_a.push_back(int'(bus.out_addr_o));
         wr_d.push_back(int'($signed(bus.out_data_o)));
      end
      if (bus.done_o) dn_e.push_back(cyc + 1);
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model();
      longint acc, r, hi, lo;
      hi = (longint'(1) <<< (WIDTH - 1)) - 1;
      lo = -(longint'(1) <<< (WIDTH - 1));
      for (int n = 0; n < OUT_LEN; n++) begin
         acc = 0;
         for (int i = 0; i < IN_LEN; i++) acc += longint'(in_v[i]) * longint'(w_v[n][i]);
         r = (acc >>> FRAC) + longint'(b_v[n]);
         r = r > hi ? hi : r < lo ? lo : r;
`ifdef DENSE_MAC_RELU_EN
         if (r < 0) r = 0;
`endif
         exp_v[n] = r;
      end
   endtask

   task automatic set_all(input int iv, input int wv, input int bv);
      for (int i = 0; i < IN_LEN; i++) in_v[i] = iv;
      for (int n = 0; n < OUT_LEN; n++) begin
         b_v[n] = bv;
         for (int i = 0; i < IN_LEN; i++) w_v[n][i] = wv;
      end
   endtask

   function automatic int rnd(input int lim);
      return int'($urandom_range(0, 2 * lim)) - lim;
   endfunction

   task automatic clear_log();
      wr_e.delete(); wr_a.delete(); wr_d.delete(); dn_e.delete();
   endtask

   task automatic run_layer(input string tag, input int repulse);
      int k;
      model();
      clear_log();
      @(negedge clk); bus.start_i = 1; k = cyc + 1;
      @(negedge clk); bus.start_i = 0;
      if (repulse > 0) begin
         repeat (repulse) @(negedge clk);
         bus.start_i = 1;
         @(negedge clk); bus.start_i = 0;
      end
      for (int t = 0; t < 200 && dn_e.size() == 0; t++) @(negedge clk);
      repeat (3) @(negedge clk);
      check({tag, ":writes"}, wr_e.size(), OUT_LEN);
      check({tag, ":dones"}, dn_e.size(), 1);
      for (int i = 0; i < OUT_LEN; i++) if (i < wr_e.size()) begin
         check({tag, ":addr"}, wr_a[i], i);
         check({tag, ":data"}, wr_d[i], exp_v[i]);
         check({tag, ":we_edge"}, wr_e[i], k + (i + 1) * NEURON_CYC);
      end
      if (dn_e.size() > 0) check({tag, ":done_edge"}, dn_e[0], k + LAYER_CYC);
      check({tag, ":busy_end"}, bus.busy_o, 0);
   endtask

   task automatic first_is(input string tag, input int val);
      check(tag, wr_d.size() > 0 ? wr_d[0] : -99999, val);
   endtask

   initial begin
      int k, dones, low, maxlow;
      bus.start_i = 0;
      set_all(0, 0, 0);
      #1 rst = 1;
      repeat (3) @(negedge clk);
      rst = 0;
      @(negedge clk);
      check("rst:busy", bus.busy_o, 0);
      check("rst:done", bus.done_o, 0);
      check("rst:we", bus.out_we_o, 0);
      check("rst:in_addr", bus.in_addr_o, 0);
      check("rst:w_addr", bus.w_addr_o, 0);
      check("rst:b_addr", bus.b_addr_o, 0);
      check("rst:out_addr", bus.out_addr_o, 0);
      check("rst:out_data", bus.out_data_o, 0);

      set_all(256, 128, 256);     run_layer("basic", 0);   first_is("basic_lit", 1536);
      set_all(32767, 32767, 0);   run_layer("sat_pos", 0); first_is("sat_pos_lit", 32767);
      set_all(32767, -32768, 0);  run_layer("sat_neg", 0);
`ifdef DENSE_MAC_RELU_EN
      first_is("sat_neg_lit", 0);
`else
      first_is("sat_neg_lit", -32768);
`endif
      set_all(-256, 128, 0);      run_layer("neg", 0);
`ifdef DENSE_MAC_RELU_EN
      first_is("neg_lit", 0);
`else
      first_is("neg_lit", -1280);
`endif
      set_all(0, 0, 0);
      for (int i = 0; i < IN_LEN; i++) in_v[i] = i + 1;
      for (int n = 0; n < OUT_LEN; n++) w_v[n][GROUPS*LANES-1] = 256;
      run_layer("lanes", 0);      first_is("lanes_lit", 10);

      set_all(256, 128, 256);     run_layer("repulse", 2);

      // start in the done cycle: second layer back to back
      set_all(300, -200, 17);
      model();
      clear_log();
      dones = 0; low = 0; maxlow = 0;
      @(negedge clk); bus.start_i = 1; k = cyc + 1;
      for (int t = 0; t < 100 && dones < 2; t++) begin
         @(negedge clk);
         bus.start_i = 0;
         if (bus.done_o) begin
            dones++;
            if (dones == 1) bus.start_i = 1;
         end
         low = bus.busy_o ? 0 : low + 1;
         if (low > maxlow) maxlow = low;
      end
      repeat (3) @(negedge clk);
      check("chain:dones", dn_e.size(), 2);
      check("chain:writes", wr_d.size(), 2 * OUT_LEN);
      check("chain:busy_gap", maxlow, 1);
      for (int i = 0; i < 2 * OUT_LEN; i++) if (i < wr_d.size()) check("chain:data", wr_d[i], exp_v[i % OUT_LEN]);
      if (dn_e.size() > 1) check("chain:done2_edge", dn_e[1], k + 2 * LAYER_CYC);

      // reset during neuron 1 FETCH
      set_all(256, 128, 256);
      clear_log();
      @(negedge clk); bus.start_i = 1; k = cyc + 1;
      @(negedge clk); bus.start_i = 0;
      for (int t = 0; t < 50 && cyc < k + NEURON_CYC + 1; t++) @(negedge clk);
      check("abort:b_addr_pre", bus.b_addr_o, 1);
      rst = 1;
      #1;
      check("abort:busy", bus.busy_o, 0);
      check("abort:we", bus.out_we_o, 0);
      check("abort:out_data", bus.out_data_o, 0);
      check("abort:w_addr", bus.w_addr_o, 0);
      repeat (2) @(negedge clk);
      rst = 0;
      repeat (12) @(negedge clk);
      check("abort:writes", wr_e.size(), 1);
      check("abort:dones", dn_e.size(), 0);
      run_layer("post_abort", 0); first_is("post_abort_lit", 1536);

      for (int r = 0; r < 6; r++) begin
         int lim;
         lim = (r % 2 == 0) ? 32767 : 400;
         for (int i = 0; i < IN_LEN; i++) in_v[i] = rnd(lim);
         for (int n = 0; n < OUT_LEN; n++) begin
            b_v[n] = rnd(lim);
            for (int i = 0; i < IN_LEN; i++) w_v[n][i] = rnd(lim);
         end
         run_layer("random", 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
